// File: rtl/game_counter_if.sv
// Stimulus/status bundle for game_counter: load/mode inputs and the scored outputs.
// Inputs are sampled on every rising edge; there is no valid/ready handshake.
interface game_counter_if #(
    parameter int WIDTH = 4
);
    logic             INIT;
    logic [WIDTH-1:0] initial_value;
    logic [1:0]       control;
    logic [WIDTH-1:0] counter;
    logic             WINNER;
    logic             LOSER;
    logic             GAMEOVER;
    logic [1:0]       WHO;

    modport master (
        output INIT, initial_value, control,
        input  counter, WINNER, LOSER, GAMEOVER, WHO
    );

    modport slave (
        input  INIT, initial_value, control,
        output counter, WINNER, LOSER, GAMEOVER, WHO
    );
endinterface

// File: rtl/game_counter.sv
// Multi-mode up/down counter with win/lose tallies and a one-cycle game-over pulse.
// Optional macro GAME_TALLY_OUT_EN exposes the internal tallies as outputs.
module game_counter #(
    parameter int WIDTH      = 4,
    parameter int GAME_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
`ifdef GAME_TALLY_OUT_EN
    output logic [3:0]        winner_tally,
    output logic [3:0]        loser_tally,
`endif
    game_counter_if.slave     bus
);
    localparam logic [3:0] LIMIT = 4'(GAME_LIMIT);

    logic [WIDTH-1:0] next_count;
    logic [3:0]       win_tally;
    logic [3:0]       lose_tally;
    logic             game_end;

    always_comb begin
        next_count = bus.counter;
        if (bus.INIT) begin
            next_count = bus.initial_value;
        end else begin
            case (bus.control)
                2'b00:   next_count = bus.counter + WIDTH'(1);
                2'b01:   next_count = bus.counter + WIDTH'(2);
                2'b10:   next_count = bus.counter - WIDTH'(1);
                default: next_count = bus.counter - WIDTH'(2);
            endcase
        end
    end

    assign game_end = (win_tally == LIMIT) || (lose_tally == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.counter  <= '0;
            bus.WINNER   <= 1'b0;
            bus.LOSER    <= 1'b0;
            bus.GAMEOVER <= 1'b0;
            bus.WHO      <= 2'b00;
            win_tally    <= '0;
            lose_tally   <= '0;
        end else begin
            bus.counter <= next_count;
            bus.WINNER  <= (next_count == {WIDTH{1'b1}});
            bus.LOSER   <= (next_count == '0);
            if (game_end) begin
                // Loser takes priority when both tallies hit the limit together.
                bus.GAMEOVER <= 1'b1;
                bus.WHO      <= (lose_tally == LIMIT) ? 2'b01 : 2'b10;
                win_tally    <= '0;
                lose_tally   <= '0;
            end else begin
                bus.GAMEOVER <= 1'b0;
                bus.WHO      <= 2'b00;
                if (bus.WINNER) win_tally  <= win_tally + 4'd1;
                if (bus.LOSER)  lose_tally <= lose_tally + 4'd1;
            end
        end
    end

`ifdef GAME_TALLY_OUT_EN
    assign winner_tally = win_tally;
    assign loser_tally  = lose_tally;
`endif
endmodule

// File: tb/tb_game_counter.sv
// Directed + random bench for game_counter with a reference model feeding an expected queue.
module tb_game_counter;
    localparam int WIDTH = 4;
    localparam int W     = WIDTH + 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_counter_if #(.WIDTH(WIDTH)) bus();

`ifdef GAME_TALLY_OUT_EN
    logic [3:0] winner_tally;
    logic [3:0] loser_tally;
    game_counter #(.WIDTH(WIDTH), .GAME_LIMIT(15)) dut (
        .clk(clk), .reset(reset),
        .winner_tally(winner_tally), .loser_tally(loser_tally),
        .bus(bus)
    );
`else
    game_counter #(.WIDTH(WIDTH), .GAME_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_cnt = 0, m_win = 0, m_lose = 0, m_wt = 0, m_lt = 0, m_go = 0, m_who = 0;

    task automatic model_step(input logic rst, input logic init, input int iv, input int ctrl);
        int nxt;
        int delta;
        if (rst) begin
            m_cnt = 0; m_win = 0; m_lose = 0; m_wt = 0; m_lt = 0; m_go = 0; m_who = 0;
        end else begin
            case (ctrl)
                0: delta = 1;
                1: delta = 2;
                2: delta = -1;
                default: delta = -2;
            endcase
            nxt = init ? iv : (m_cnt + delta + 16) % 16;
            if (m_wt == 15 || m_lt == 15) begin
                m_go  = 1;
                m_who = (m_lt == 15) ? 1 : 2;
                m_wt  = 0;
                m_lt  = 0;
            end else begin
                m_go  = 0;
                m_who = 0;
                m_wt  = m_wt + m_win;
                m_lt  = m_lt + m_lose;
            end
            m_win  = (nxt == 15) ? 1 : 0;
            m_lose = (nxt == 0) ? 1 : 0;
            m_cnt  = nxt;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic init,
                        input int iv, input int ctrl);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        reset             = rst;
        bus.INIT          = init;
        bus.initial_value = WIDTH'(iv);
        bus.control       = 2'(ctrl);
        model_step(rst, init, iv, ctrl);
        exp_q.push_back({WIDTH'(m_cnt), m_win[0], m_lose[0], m_go[0], 2'(m_who)});
        @(posedge clk);
        #1;
        obs = {bus.counter, bus.WINNER, bus.LOSER, bus.GAMEOVER, bus.WHO};
        exp = exp_q.pop_front();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cnt/win/lose/go/who observed=%h_%b%b%b_%b expected=%h_%b%b%b_%b",
                   tag, obs[W-1:5], obs[4], obs[3], obs[2], obs[1:0],
                   exp[W-1:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
`ifdef GAME_TALLY_OUT_EN
        vectors++;
        assert ({winner_tally, loser_tally} === {4'(m_wt), 4'(m_lt)}) else begin
            miscompares++;
            $error("FAIL %s_tally observed=%h/%h expected=%0d/%0d",
                   tag, winner_tally, loser_tally, m_wt, m_lt);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        bus.INIT = 1'b0;
        bus.initial_value = '0;
        bus.control = 2'b00;

        step("reset", 1, 0, 0, 0);
        step("reset", 1, 0, 0, 0);
        vectors++;
        assert (bus.LOSER === 1'b0 && bus.counter === 4'd0) else begin
            miscompares++;
            $error("FAIL reset_loser observed=%b/%h expected=0/0", bus.LOSER, bus.counter);
        end

        for (int i = 0; i < 16; i++) step("up1", 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("up2", 0, 0, 0, 1);
        step("load1", 0, 1, 1, 3);
        for (int i = 0; i < 8; i++) step("down2", 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) step("down1", 0, 0, 0, 2);

        step("reset", 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) step("hold15", 0, 1, 15, 0);
        for (int i = 0; i < 3; i++) step("after_win", 0, 0, 0, 2);

        step("reset", 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) step("hold0", 0, 1, 0, 0);

        step("reset", 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step("mid15", 0, 1, 15, 0);
        step("mid9", 0, 1, 9, 0);
        step("mid_reset", 1, 0, 0, 0);
        vectors++;
        assert ({bus.counter, bus.WINNER, bus.LOSER, bus.GAMEOVER, bus.WHO} === 9'd0) else begin
            miscompares++;
            $error("FAIL mid_reset_outputs observed=%h_%b%b%b_%b expected=0",
                   bus.counter, bus.WINNER, bus.LOSER, bus.GAMEOVER, bus.WHO);
        end
        for (int i = 0; i < 18; i++) step("regame15", 0, 1, 15, 0);

        for (int i = 0; i < 60; i++)
            step("random", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
